// File: rtl/video_timing_pkg.sv
// video_timing_pkg: recovery FSM state type and 720p timing defaults shared by the video blocks
package video_timing_pkg;
  typedef enum logic [1:0] {SEEK, ALIGN, TRACK} recover_state_t;
  localparam int DEF_ACTIVE_H_PIXELS = 1280;
  localparam int DEF_H_FRONT_PORCH   = 110;
  localparam int DEF_H_SYNC_WIDTH    = 40;
  localparam int DEF_H_BACK_PORCH    = 220;
  localparam int DEF_ACTIVE_LINES    = 720;
  localparam int DEF_V_FRONT_PORCH   = 5;
  localparam int DEF_V_SYNC_WIDTH    = 5;
  localparam int DEF_V_BACK_PORCH    = 20;
  localparam int DEF_LOCK_FRAMES     = 2;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: registers one bit and flags its rising (RISING=1) or falling (RISING=0) edge
//   clk_pixel_in / rst_in : pixel clock, synchronous active-low reset
//   d : raw input bit, q : registered copy, pulse : edge flag
// The edge is taken between the incoming bit and its registered copy, so the pulse is
// high in the cycle before q shows the new level; an action loaded on the pulse lines up
// with the first cycle q carries that level.
module sync_edge_det #(
  parameter bit RISING = 1'b1
) (
  input  logic clk_pixel_in,
  input  logic rst_in,
  input  logic d,
  output logic q,
  output logic pulse
);
  always_ff @(posedge clk_pixel_in) q <= rst_in & d;
  assign pulse = RISING ? (d & ~q) : (~d & q);
endmodule

// File: rtl/video_sig_recover.sv
// video_sig_recover: locks a flywheel to an incoming hs/vs/ad stream and regenerates coordinates
//   clk_pixel_in / rst_in : pixel clock, synchronous active-low reset
//   hs_in, vs_in, ad_in   : raw syncs and data-enable
//   hcount_out/vcount_out : recovered coordinates (0 while not tracking), aligned with ad_out
//   hs_out, vs_out, ad_out: inputs delayed two cycles
//   nf_out, fc_out        : new-frame pulse while locked, frame count 0..59
//   locked_out, err_out   : flywheel locked, one-cycle timing-violation pulse
module video_sig_recover import video_timing_pkg::*; #(
  parameter int ACTIVE_H_PIXELS = DEF_ACTIVE_H_PIXELS,
  parameter int H_FRONT_PORCH   = DEF_H_FRONT_PORCH,
  parameter int H_SYNC_WIDTH    = DEF_H_SYNC_WIDTH,
  parameter int H_BACK_PORCH    = DEF_H_BACK_PORCH,
  parameter int ACTIVE_LINES    = DEF_ACTIVE_LINES,
  parameter int V_FRONT_PORCH   = DEF_V_FRONT_PORCH,
  parameter int V_SYNC_WIDTH    = DEF_V_SYNC_WIDTH,
  parameter int V_BACK_PORCH    = DEF_V_BACK_PORCH,
  parameter int LOCK_FRAMES     = DEF_LOCK_FRAMES,
  localparam int TOTAL_COLS  = ACTIVE_H_PIXELS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH,
  localparam int TOTAL_LINES = ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH,
  localparam int HW = $clog2(TOTAL_COLS),
  localparam int VW = $clog2(TOTAL_LINES)
) (
  input  logic          clk_pixel_in,
  input  logic          rst_in,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic          ad_in,
  output logic [HW-1:0] hcount_out,
  output logic [VW-1:0] vcount_out,
  output logic          hs_out,
  output logic          vs_out,
  output logic          ad_out,
  output logic          nf_out,
  output logic [5:0]    fc_out,
  output logic          locked_out,
  output logic          err_out
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  recover_state_t state, state_nxt;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [GW-1:0] good;
  logic hs_r, vs_r, ad_r, vs_fall, ad_rise;
  logic trk, h_wrap, v_wrap, frame_end, exp_ad, exp_vs, err;
  sync_edge_det #(.RISING(1'b0)) u_vs (
    .clk_pixel_in(clk_pixel_in), .rst_in(rst_in), .d(vs_in), .q(vs_r), .pulse(vs_fall)
  );
  sync_edge_det #(.RISING(1'b1)) u_ad (
    .clk_pixel_in(clk_pixel_in), .rst_in(rst_in), .d(ad_in), .q(ad_r), .pulse(ad_rise)
  );
  assign trk       = state == TRACK;
  assign h_wrap    = int'(h) == TOTAL_COLS - 1;
  assign v_wrap    = int'(v) == TOTAL_LINES - 1;
  assign frame_end = trk && h_wrap && v_wrap;
  assign exp_ad    = int'(h) < ACTIVE_H_PIXELS && int'(v) < ACTIVE_LINES;
  assign exp_vs    = int'(v) >= ACTIVE_LINES + V_FRONT_PORCH
                  && int'(v) < ACTIVE_LINES + V_FRONT_PORCH + V_SYNC_WIDTH;
  // h/v describe the pixel currently held in the input registers
  assign err       = trk && (ad_r != exp_ad || (h == '0 && vs_r != exp_vs));
  assign nf_out    = locked_out && int'(hcount_out) == ACTIVE_H_PIXELS
                  && int'(vcount_out) == ACTIVE_LINES;
  always_comb begin
    state_nxt = state;
    if (err) state_nxt = SEEK;
    else if (state == SEEK && vs_fall) state_nxt = ALIGN;
    else if (state == ALIGN && ad_rise) state_nxt = TRACK;
  end
  always_ff @(posedge clk_pixel_in) begin
    if (!rst_in) begin
      state      <= SEEK;
      h          <= '0;
      v          <= '0;
      good       <= '0;
      hs_r       <= 1'b0;
      {hs_out, vs_out, ad_out, locked_out, err_out} <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
      fc_out     <= '0;
    end else begin
      state      <= state_nxt;
      hs_r       <= hs_in;
      {hs_out, vs_out, ad_out} <= {hs_r, vs_r, ad_r};
      hcount_out <= trk ? h : '0;
      vcount_out <= trk ? v : '0;
      err_out    <= err;
      // flywheel parks at 0 outside TRACK so entry from ALIGN starts at the first active pixel
      h          <= trk ? (h_wrap ? '0 : h + 1'b1) : '0;
      v          <= trk ? (h_wrap ? (v_wrap ? '0 : v + 1'b1) : v) : '0;
      good       <= err ? '0 : ((frame_end && int'(good) != LOCK_FRAMES) ? good + 1'b1 : good);
      locked_out <= err ? 1'b0 : ((frame_end && int'(good) >= LOCK_FRAMES - 1) ? 1'b1 : locked_out);
      fc_out     <= nf_out ? (fc_out == 6'd59 ? '0 : fc_out + 1'b1) : fc_out;
    end
  end
endmodule

// File: tb/tb_video_sig_recover.sv
// tb_video_sig_recover: random-fault stream against a position-based reference of the recovery rules
module tb_video_sig_recover;
  localparam int AH = 8, HFP = 2, HSW = 2, HBP = 3;
  localparam int AL = 6, VFP = 1, VSW = 2, VBP = 2, LF = 2;
  localparam int TC = AH + HFP + HSW + HBP, TL = AL + VFP + VSW + VBP, FRAME = TC * TL;
  localparam int HW = $clog2(TC), VW = $clog2(TL);
  logic clk_pixel_in = 1'b0, rst_in = 1'b0, hs_in = 1'b0, vs_in = 1'b0, ad_in = 1'b0;
  logic [HW-1:0] hcount_out;
  logic [VW-1:0] vcount_out;
  logic hs_out, vs_out, ad_out, nf_out, locked_out, err_out;
  logic [5:0] fc_out;
  video_sig_recover #(
    .ACTIVE_H_PIXELS(AH), .H_FRONT_PORCH(HFP), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
    .ACTIVE_LINES(AL), .V_FRONT_PORCH(VFP), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP),
    .LOCK_FRAMES(LF)
  ) dut (
    .clk_pixel_in(clk_pixel_in), .rst_in(rst_in), .hs_in(hs_in), .vs_in(vs_in), .ad_in(ad_in),
    .hcount_out(hcount_out), .vcount_out(vcount_out), .hs_out(hs_out), .vs_out(vs_out),
    .ad_out(ad_out), .nf_out(nf_out), .fc_out(fc_out), .locked_out(locked_out), .err_out(err_out)
  );
  always #5 clk_pixel_in = ~clk_pixel_in;
  int n_cmp = 0, n_bad = 0, n_err = 0, n_nf = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  // stream generator: position of the pixel being sent, plus injected faults
  int gh = 0, gv = 0, drop_h, drop_v, stretch_v;
  bit drop_arm = 0, stretch_arm = 0, garbage = 0;
  task automatic drive_inputs();
    if (garbage) begin
      hs_in = 1'($urandom_range(1));
      vs_in = 1'($urandom_range(1));
      ad_in = 1'($urandom_range(1));
    end else begin
      hs_in = gh >= AH + HFP && gh < AH + HFP + HSW;
      vs_in = gv >= AL + VFP && gv < AL + VFP + VSW;
      ad_in = gh < AH && gv < AL && !(drop_arm && gh == drop_h && gv == drop_v);
    end
  endtask
  task automatic advance();
    if (drop_arm && gh == drop_h && gv == drop_v) drop_arm = 0;
    if (stretch_arm && gv == stretch_v && gh == TC - 1) begin
      stretch_arm = 0;
      return;
    end
    gh = (gh == TC - 1) ? 0 : gh + 1;
    if (gh == 0) gv = (gv == TL - 1) ? 0 : gv + 1;
  endtask
  // reference: tracking is described by the sample offset from the anchoring ad rise
  bit m_pvs, m_pad, m_arm, m_skip, m_trk, m_lck;
  longint m_pos;
  bit s_hs, s_vs, s_ad, s_trk, s_err, s_lck;
  int s_h, s_v;
  bit e_hs, e_vs, e_ad, e_trk, e_err, e_lck, e_nf;
  int e_h, e_v, e_fc;
  task automatic model_step(input bit hs, input bit vs, input bit ad, input bit rst);
    int h, v;
    bit bad;
    if (!rst) begin
      {m_pvs, m_pad, m_arm, m_skip, m_trk, m_lck} = '0;
      {s_hs, s_vs, s_ad, s_trk, s_err, s_lck} = '0;
      {e_hs, e_vs, e_ad, e_trk, e_err, e_lck, e_nf} = '0;
      s_h = 0; s_v = 0; e_h = 0; e_v = 0; e_fc = 0;
      return;
    end
    if (e_nf) e_fc = (e_fc + 1) % 60;
    {e_hs, e_vs, e_ad, e_trk, e_err, e_lck} = {s_hs, s_vs, s_ad, s_trk, s_err, s_lck};
    e_h = s_h; e_v = s_v;
    e_nf = e_trk && e_lck && e_h == AH && e_v == AL;
    {s_hs, s_vs, s_ad} = {hs, vs, ad};
    s_trk = 0; s_err = 0; s_h = 0; s_v = 0;
    if (m_trk) m_pos++;
    else if (m_skip) m_skip = 0;
    else if (!m_arm) m_arm = m_pvs && !vs;
    else if (ad && !m_pad) begin
      m_trk = 1;
      m_pos = 0;
    end
    if (m_trk) begin
      h = int'(m_pos % TC);
      v = int'((m_pos / TC) % TL);
      bad = ad != (h < AH && v < AL) || (h == 0 && vs != (v >= AL + VFP && v < AL + VFP + VSW));
      s_trk = 1; s_h = h; s_v = v; s_err = bad;
      if (bad) begin
        m_trk = 0; m_arm = 0; m_skip = 1; m_lck = 0;
      end else m_lck = (m_pos + 1) / FRAME >= LF;
    end
    s_lck = m_lck;
    m_pvs = vs;
    m_pad = ad;
  endtask
  task automatic tick();
    drive_inputs();
    @(posedge clk_pixel_in);
    model_step(hs_in, vs_in, ad_in, rst_in);
    #1;
    check("hcount", 32'(hcount_out), e_trk ? e_h : 0);
    check("vcount", 32'(vcount_out), e_trk ? e_v : 0);
    check("syncs", 32'({hs_out, vs_out, ad_out}), 32'({e_hs, e_vs, e_ad}));
    check("nf", 32'(nf_out), 32'(e_nf));
    check("fc", 32'(fc_out), e_fc);
    check("locked", 32'(locked_out), 32'(e_lck));
    check("err", 32'(err_out), 32'(e_err));
    if (err_out) n_err++;
    if (nf_out) n_nf++;
    advance();
  endtask
  task automatic run(input int n);
    repeat (n) tick();
  endtask
  initial begin
    run(3);
    gv = $urandom_range(TL - 1, 1);
    gh = $urandom_range(TC - 1);
    rst_in = 1'b1;
    n_err = 0;
    run(5 * FRAME);
    check("lock_initial", 32'(locked_out), 1);
    check("err_initial", n_err, 0);
    drop_h = $urandom_range(AH - 1);
    drop_v = $urandom_range(AL - 1);
    drop_arm = 1;
    n_err = 0;
    run(FRAME + 4);
    check("drop_err_count", n_err, 1);
    check("drop_unlocked", 32'(locked_out), 0);
    run(4 * FRAME);
    check("relock_drop", 32'(locked_out), 1);
    stretch_v = $urandom_range(AL - 2);
    stretch_arm = 1;
    n_err = 0;
    run(FRAME + 4);
    check("stretch_err_count", n_err, 1);
    check("stretch_unlocked", 32'(locked_out), 0);
    run(4 * FRAME);
    check("relock_stretch", 32'(locked_out), 1);
    n_nf = 0;
    n_err = 0;
    run(61 * FRAME);
    check("nf_61_frames", n_nf, 61);
    check("err_61_frames", n_err, 0);
    for (int i = 0; i < 2 * FRAME && !(gh == 0 && gv == 3); i++) tick();
    rst_in = 1'b0;
    tick();
    rst_in = 1'b1;
    check("rst_locked", 32'(locked_out), 0);
    check("rst_fc", 32'(fc_out), 0);
    run(5 * FRAME);
    check("relock_reset", 32'(locked_out), 1);
    garbage = 1;
    run(200);
    garbage = 0;
    gv = $urandom_range(TL - 1);
    gh = $urandom_range(TC - 1);
    run(5 * FRAME);
    check("relock_garbage", 32'(locked_out), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
